// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - radix-2 shift-add multiplier, N+1 cycles per 2N-bit product
// Optional SEQ_MUL_SIGNED_EN adds op_signed for two's-complement operands.
module seq_multiplier #(
   parameter int N = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] rs1,
   input  logic [N-1:0] rs2,
`ifdef SEQ_MUL_SIGNED_EN
   input  logic         op_signed,
`endif
   output logic         busy,
   output logic         done,
   output logic [N-1:0] rd_lo,
   output logic [N-1:0] rd_hi
);

   localparam int CW = $clog2(N) + 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [N:0]    acc_q, acc_d;
   logic [N-1:0]  mq_q, mq_d;
   logic [N-1:0]  md_q, md_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  rd_lo_q, rd_lo_d;
   logic [N-1:0]  rd_hi_q, rd_hi_d;

   logic [N:0]     sum;
   logic [2*N-1:0] prod;
   logic [2*N-1:0] result;
   logic [N-1:0]   ld_md;
   logic [N-1:0]   ld_mq;

`ifdef SEQ_MUL_SIGNED_EN
   localparam logic [N-1:0]   ONE_N  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};
   logic neg_q, neg_d;
   logic neg1, neg2;
`endif

   always_comb begin
      sum  = mq_q[0] ? ({1'b0, acc_q[N-1:0]} + {1'b0, md_q}) : acc_q;
      // Final {acc[N-1:0], mq} after this edge's shift.
      prod = {sum, mq_q[N-1:1]};
`ifdef SEQ_MUL_SIGNED_EN
      neg1   = op_signed & rs1[N-1];
      neg2   = op_signed & rs2[N-1];
      ld_md  = neg1 ? (~rs1 + ONE_N) : rs1;
      ld_mq  = neg2 ? (~rs2 + ONE_N) : rs2;
      result = neg_q ? (~prod + ONE_2N) : prod;
`else
      ld_md  = rs1;
      ld_mq  = rs2;
      result = prod;
`endif
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      md_d    = md_q;
      cnt_d   = cnt_q;
      rd_lo_d = rd_lo_q;
      rd_hi_d = rd_hi_q;
`ifdef SEQ_MUL_SIGNED_EN
      neg_d   = neg_q;
`endif
      case (state_q)
         S_RUN: begin
            acc_d = {1'b0, sum[N:1]};
            mq_d  = {sum[0], mq_q[N-1:1]};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               {rd_hi_d, rd_lo_d} = result;
               state_d = S_DONE;
            end
         end
         default: begin
            // IDLE and DONE both accept a new request.
            if (start) begin
               md_d    = ld_md;
               mq_d    = ld_mq;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef SEQ_MUL_SIGNED_EN
               neg_d   = neg1 ^ neg2;
`endif
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         acc_q   <= '0;
         mq_q    <= '0;
         md_q    <= '0;
         cnt_q   <= '0;
         rd_lo_q <= '0;
         rd_hi_q <= '0;
`ifdef SEQ_MUL_SIGNED_EN
         neg_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         md_q    <= md_d;
         cnt_q   <= cnt_d;
         rd_lo_q <= rd_lo_d;
         rd_hi_q <= rd_hi_d;
`ifdef SEQ_MUL_SIGNED_EN
         neg_q   <= neg_d;
`endif
      end
   end

   assign busy  = (state_q == S_RUN);
   assign done  = (state_q == S_DONE);
   assign rd_lo = rd_lo_q;
   assign rd_hi = rd_hi_q;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle radix-2 shift-add multiplier that forms the 2N-bit product of two N-bit operands. It is the counterpart to the team's divider in the CPU execute stage: the divider decomposes a value by repeated subtraction, and this block builds one by repeated addition. It uses a start/done handshake so the ALU can issue a MUL and stall until the result is ready. There is one iteration per cycle and no multiplier array.

## Interface
- `N`, default 16: operand width; product width is 2N.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `start` input 1: request; sampled only when the block is idle (state IDLE or DONE).
- `rs1` input N: multiplicand; captured on the accepted start edge.
- `rs2` input N: multiplier; captured on the accepted start edge.
- `busy` output 1: high while iterating (state RUN).
- `done` output 1: one-cycle pulse when the result is valid.
- `rd_lo` output N: product bits [N-1:0].
- `rd_hi` output N: product bits [2N-1:N].

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN on `start`.
  - RUN → DONE after N iterations.
  - DONE → RUN on `start`, otherwise DONE → IDLE.
- Datapath:
  - Accumulator `acc`, N+1 bits (includes carry).
  - Shift register `mq`, N bits, loaded with `rs2`.
  - Multiplicand register `md`, N bits, loaded with `rs1`.
  - Iteration counter, ceil(log2 N)+1 bits.
- On an accepted start:
  - `md`←`rs1`, `mq`←`rs2`, `acc`←0, counter←0.
  - `rd_hi`/`rd_lo` keep their previous values until completion.
- Each RUN edge:
  - If `mq[0]`, then `sum = acc[N-1:0] + md` (N+1 bits), else `sum = acc`.
  - `{acc, mq} ← {1'b0, sum, mq} >> 1`, keeping 2N+1 bits.
  - Counter increments.
- On the Nth RUN edge:
  - `{rd_hi, rd_lo}` ← final `{acc[N-1:0], mq}`.
  - State goes to DONE.
- Arithmetic is unsigned modulo-free: the full 2N-bit product is always exact and there is no overflow flag.
- `start` while RUN is ignored, with no queueing. Operand input changes during RUN are ignored.
- Zero operands take the full latency; there is no early termination.

## Timing
- Reset values (`rst_n` low at an edge, regardless of state):
  - state IDLE, `busy`=0, `done`=0, `rd_hi`=0, `rd_lo`=0.
  - Counter and internal registers are 0.
- Reset mid-RUN aborts the operation. No `done` follows.
- Latency: `start` sampled at edge E0, then `busy`=1 from E0 through EN.
  - Result registers update at EN.
  - `done`=1 for the single cycle between EN and EN+1, where `busy`=0.
  - That is N+1 cycles from request to `done`.
- `rd_hi`/`rd_lo` hold the last result until the next completion or reset.
- A `start` during the DONE cycle is accepted, giving a back-to-back issue. `done` still pulses in that cycle and the next result follows N+1 cycles later.
- Throughput: one product per N+1 cycles.

## Configuration
- Macro: `SEQ_MUL_SIGNED_EN`.
- **Without the macro:** operands are unsigned only. No extra port.
- **With the macro:** an extra input port `op_signed` (input, 1 bit) is added and sampled with `start`.
  - When `op_signed`=1, `rs1` and `rs2` are two's complement.
  - At load, their magnitudes (N-bit unsigned; -2^(N-1) maps to 2^(N-1)) go into `md`/`mq`, and the sign XOR is registered.
  - On the Nth edge the 2N-bit result is two's-complement negated if the sign XOR is 1.
  - Latency is unchanged.
  - When `op_signed`=0, behaviour is identical to the unsigned build.

## Test plan
- Reset, then `rs1`=3, `rs2`=5, pulse `start` → `busy` for 16 cycles; `done` at cycle 17; `rd_hi`=0x0000, `rd_lo`=0x000F.
- `rs1`=0xFFFF, `rs2`=0xFFFF → `rd_hi`=0xFFFE, `rd_lo`=0x0001. This exercises the carry into `acc[N]`.
- Start with 7×9; mid-RUN change operands to 2×2 and re-pulse `start` → exactly one `done`, with product 0x003F.
- Start 0x1234×0x0100, assert `rst_n`=0 at RUN cycle 8 → all outputs 0, no `done`. A following 2×3 gives 6.
- Back-to-back: 10×10, with `start` held in the DONE cycle carrying 0×0x8000 → first `done` gives 0x0064, second `done` 17 cycles later gives 0.
- With `SEQ_MUL_SIGNED_EN` and `op_signed`=1:
  - -3×5 (0xFFFD×0x0005) → `rd_hi`=0xFFFF, `rd_lo`=0xFFF1.
  - 0x8000×0x8000 → `rd_hi`=0x4000, `rd_lo`=0x0000.
